// File: rtl/log2_frac_seq_pkg.sv
// Shared constants and state encoding for the iterative mantissa log2 unit.
package log2_frac_seq_pkg;

    localparam int MAN_W_LOG  = 16;
    localparam int FRAC_W_LOG = 16;
    localparam int TAG_W_LOG  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/log2_frac_seq_if.sv
// Valid/ready request and result bundle for log2_frac_seq.
interface log2_frac_seq_if
    import log2_frac_seq_pkg::*;
#(
    parameter int MAN_W  = MAN_W_LOG,
    parameter int FRAC_W = FRAC_W_LOG,
    parameter int TAG_W  = TAG_W_LOG
);

    logic              in_valid;
    logic              in_ready;
    logic [MAN_W-1:0]  in_man;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [FRAC_W-1:0] out_frac;
    logic [TAG_W-1:0]  out_tag;
    logic              out_exact;
    logic              out_err;

    modport master (
        output in_valid, in_man, in_tag, out_ready,
        input  in_ready, out_valid, out_frac, out_tag, out_exact, out_err
    );

    modport slave (
        input  in_valid, in_man, in_tag, out_ready,
        output in_ready, out_valid, out_frac, out_tag, out_exact, out_err
    );

endinterface

// File: rtl/log2_frac_seq_sq.sv
// One squaring step of the log2 bit recurrence: square, renormalise, emit one bit.
module log2_sq_step #(
    parameter int MAN_W = 16
) (
    input  logic [MAN_W-1:0] x,
    output logic             frac_bit,
    output logic [MAN_W-1:0] x_next,
    output logic             is_one
);

    logic [2*MAN_W-1:0] p;
    logic [MAN_W-2:0]   unused_low;

    assign p        = {{MAN_W{1'b0}}, x} * {{MAN_W{1'b0}}, x};
    assign frac_bit = p[2*MAN_W-1];

    // p is Q2.(2MAN_W-2); a set top bit means x*x >= 2, so halve (shift the window up).
    assign {x_next, unused_low} = frac_bit ? p[2*MAN_W-1:1] : p[2*MAN_W-2:0];

    assign is_one = (x == {1'b1, {(MAN_W-1){1'b0}}});

endmodule

// File: rtl/log2_frac_seq.sv
// Sequential log2(1.M) fraction generator, one result bit per cycle with early exit at 1.0.
module log2_frac_seq
    import log2_frac_seq_pkg::*;
#(
    parameter int MAN_W  = MAN_W_LOG,
    parameter int FRAC_W = FRAC_W_LOG,
    parameter int TAG_W  = TAG_W_LOG
) (
    input logic          clk,
    input logic          rst,
    log2_frac_seq_if.slave bus
);

    localparam int CNT_W = (FRAC_W > 1) ? $clog2(FRAC_W) : 1;

    state_t            state;
    state_t            state_next;
    logic [MAN_W-1:0]  x;
    logic [FRAC_W-1:0] frac;
    logic [TAG_W-1:0]  tag;
    logic              exact;
    logic              err;
    logic [CNT_W-1:0]  cnt;
    logic              frac_bit;
    logic [MAN_W-1:0]  x_next;
    logic              is_one;
    logic              accept;

    log2_sq_step #(.MAN_W(MAN_W)) u_step (
        .x        (x),
        .frac_bit (frac_bit),
        .x_next   (x_next),
        .is_one   (is_one)
    );

    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = bus.in_man[MAN_W-1] ? EVAL : DONE;
            EVAL: if (is_one || cnt == '0) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Once x hits exactly 1.0 every further square is 1.0, so the untouched low bits are already correct zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            x     <= '0;
            frac  <= '0;
            tag   <= '0;
            exact <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x     <= bus.in_man;
                        tag   <= bus.in_tag;
                        frac  <= '0;
                        exact <= 1'b0;
                        err   <= !bus.in_man[MAN_W-1];
                        cnt   <= CNT_W'(FRAC_W - 1);
                    end
                end
                EVAL: begin
                    if (is_one) begin
                        exact <= 1'b1;
                    end else begin
                        frac[cnt] <= frac_bit;
                        x         <= x_next;
                        if (cnt != '0) cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.out_frac  = frac;
    assign bus.out_tag   = tag;
    assign bus.out_exact = exact;
    assign bus.out_err   = err;

endmodule

// File: tb/tb_log2_frac_seq.sv
// Directed vector bench for log2_frac_seq at MAN_W=FRAC_W=16 (1.0 = 0x8000).
module tb_log2_frac_seq;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [15:0] man;
        logic [3:0]  tag;
        logic [15:0] frac;
        logic [15:0] tol;
        logic        exact;
        logic        err;
        int          latency;
    } vec_t;

    vec_t vecs[7];

    log2_frac_seq_if #(.MAN_W(16), .FRAC_W(16), .TAG_W(4)) bus ();

    log2_frac_seq #(.MAN_W(16), .FRAC_W(16), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input logic [15:0] actual, input logic [15:0] centre, input logic [15:0] tol);
        checks++;
        if ($isunknown(actual) || actual < centre - tol || actual > centre + tol) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h +/- %0d", name, actual, centre, tol);
        end
    endtask

    // Latency counts clock edges after the acceptance edge until out_valid is seen.
    task automatic wait_result(output int latency);
        latency = 0;
        while (!bus.out_valid && latency < 40) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] man, input logic [3:0] tag, output int latency);
        bus.in_valid = 1'b1;
        bus.in_man   = man;
        bus.in_tag   = tag;
        #1;
        check_value("in_ready before accept", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_result(latency);
    endtask

    task automatic check_output(input vec_t v, input int latency);
        check_value($sformatf("out_valid man=%h", v.man), 32'(bus.out_valid), 32'd1);
        check_value($sformatf("latency man=%h", v.man), 32'(latency), 32'(v.latency));
        if (v.tol != 0) begin
            check_range($sformatf("out_frac man=%h", v.man), bus.out_frac, v.frac, v.tol);
            check_value($sformatf("out_frac top man=%h", v.man), 32'(bus.out_frac[15:9]), 32'(v.frac[15:9]));
        end else begin
            check_value($sformatf("out_frac man=%h", v.man), 32'(bus.out_frac), 32'(v.frac));
        end
        check_value($sformatf("out_exact man=%h", v.man), 32'(bus.out_exact), 32'(v.exact));
        check_value($sformatf("out_err man=%h", v.man), 32'(bus.out_err), 32'(v.err));
        check_value($sformatf("out_tag man=%h", v.man), 32'(bus.out_tag), 32'(v.tag));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_value($sformatf("out_valid drop man=%h", v.man), 32'(bus.out_valid), 32'd0);
        check_value($sformatf("in_ready idle man=%h", v.man), 32'(bus.in_ready), 32'd1);
    endtask

    task automatic check_cleared(input string name);
        check_value({name, " out_valid"}, 32'(bus.out_valid), 32'd0);
        check_value({name, " out_frac"},  32'(bus.out_frac),  32'd0);
        check_value({name, " out_tag"},   32'(bus.out_tag),   32'd0);
        check_value({name, " out_exact"}, 32'(bus.out_exact), 32'd0);
        check_value({name, " out_err"},   32'(bus.out_err),   32'd0);
    endtask

    initial begin
        int   lat;
        vec_t v;

        // 0x9838 and 0x8B96 square (truncated) onto 0xB505 and 0x9838, giving exits after 3 and 4 steps.
        vecs[0] = '{16'h8000, 4'h3, 16'h0000, 16'd0, 1'b1, 1'b0, 1};
        vecs[1] = '{16'hB505, 4'h5, 16'h8000, 16'd0, 1'b1, 1'b0, 2};
        vecs[2] = '{16'h9838, 4'h9, 16'h4000, 16'd0, 1'b1, 1'b0, 3};
        vecs[3] = '{16'h8B96, 4'hC, 16'h2000, 16'd0, 1'b1, 1'b0, 4};
        vecs[4] = '{16'hC000, 4'h6, 16'h95C0, 16'd2, 1'b0, 1'b0, 16};
        vecs[5] = '{16'h4000, 4'hA, 16'h0000, 16'd0, 1'b0, 1'b1, 0};
        vecs[6] = '{16'h0001, 4'hF, 16'h0000, 16'd0, 1'b0, 1'b1, 0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_man    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("in_ready during rst", 32'(bus.in_ready), 32'd0);
        check_cleared("reset");
        rst = 1'b0;
        #1;
        check_value("in_ready after rst", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].man, vecs[i].tag, lat);
            check_output(vecs[i], lat);
        end

        // Backpressure: result held while a second request waits.
        apply_stimulus(16'h8000, 4'h1, lat);
        check_value("bp first latency", 32'(lat), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_man   = 16'hC000;
        bus.in_tag   = 4'h2;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check_value($sformatf("bp out_valid c%0d", c), 32'(bus.out_valid), 32'd1);
            check_value($sformatf("bp in_ready c%0d", c),  32'(bus.in_ready),  32'd0);
            check_value($sformatf("bp out_frac c%0d", c),  32'(bus.out_frac),  32'd0);
            check_value($sformatf("bp out_tag c%0d", c),   32'(bus.out_tag),   32'd1);
            check_value($sformatf("bp out_exact c%0d", c), 32'(bus.out_exact), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_value("bp release out_valid", 32'(bus.out_valid), 32'd0);
        check_value("bp release in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_value("bp second taken", 32'(bus.in_ready), 32'd0);
        wait_result(lat);
        v = vecs[4];
        v.tag = 4'h2;
        check_output(v, lat);

        // Reset during iteration 7 of a 1.5 evaluation.
        bus.in_valid = 1'b1;
        bus.in_man   = 16'hC000;
        bus.in_tag   = 4'h7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_value("mid-eval in_ready during rst", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_cleared("mid-eval rst");
        rst = 1'b0;
        #1;
        check_value("mid-eval in_ready after rst", 32'(bus.in_ready), 32'd1);
        v = vecs[0];
        v.tag = 4'h4;
        apply_stimulus(v.man, v.tag, lat);
        check_output(v, lat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/log2_frac_seq.md
# log2_frac_seq

Parametrised iterative log2 fraction unit: takes a normalised mantissa 1.M in fixed point and produces FRAC_W bits of log2(1.M) in [0,1), one bit per cycle, by repeated squaring. It is the next generation of the FLOG mantissa-log engine:

- generic widths;
- valid/ready on both sides;
- tag pass-through;
- early termination when the running value reaches exactly 1.0;
- error flagging for un-normalised input.

It sits between the exponent/mantissa split and the final exponent+fraction assembly of the bfloat16 log pipeline.

## Interface
- MAN_W, 16: input mantissa width, format Q1.(MAN_W-1); 1.0 = 1 followed by zeros.
- FRAC_W, 16: number of log2 fraction bits produced.
- TAG_W, 4: width of sideband tag carried from input to output.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input mantissa valid.
- in_ready  out  1  block can accept; = (state==IDLE) && !rst.
- in_man  in  MAN_W  mantissa, Q1.(MAN_W-1).
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result valid; registered; reset 0.
- out_ready  in  1  consumer accepts result.
- out_frac  out  FRAC_W  log2 fraction; out_frac[FRAC_W-1] has weight 2^-1; reset 0.
- out_tag  out  TAG_W  captured in_tag; reset 0.
- out_exact  out  1  finished by early exit (remaining bits exactly zero); reset 0.
- out_err  out  1  in_man[MAN_W-1]==0 (not normalised); reset 0.

## Operation
- States: IDLE, EVAL, DONE.
- IDLE, on in_valid && in_ready: capture x=in_man, tag; clear frac/exact/err; bit counter cnt=FRAC_W-1 (width $clog2(FRAC_W)).
  - If in_man[MAN_W-1]==0: err=1, frac=0, go DONE.
  - Otherwise go EVAL.
- EVAL, each cycle:
  - If x == 1.0: exact=1, remaining bits stay 0, go DONE.
  - Otherwise compute p = x*x, 2*MAN_W bits, format Q2.(2MAN_W-2).
  - If p[2MAN_W-1]: frac[cnt]=1, x=p[2MAN_W-1:MAN_W].
  - Else: frac[cnt]=0, x=p[2MAN_W-2:MAN_W-1]. Truncation only, no rounding.
  - If cnt==0, go DONE; else cnt-1.
- DONE: out_valid=1 and outputs stable. On out_ready go IDLE and drop out_valid. in_valid is ignored in DONE and EVAL.
- One multiplier, MAN_W×MAN_W unsigned, combinational from registered x.

## Timing
- Acceptance edge k; normal completion: out_valid high after edge k+FRAC_W (FRAC_W cycles latency).
- Early exit at iteration i (0-based): out_valid after edge k+i+1. An input of exactly 1.0 gives latency 1.
- Error input: out_valid after edge k (same edge as acceptance goes to DONE); visible the next cycle.
- Handshake transfer occurs on the edge where out_valid && out_ready. The earliest next acceptance is the following cycle (IDLE). No overlap, so throughput is 1 result per latency+2 cycles.
- Output data and flags are held unchanged while out_valid && !out_ready, for any duration.
- rst at any time, including mid-EVAL or DONE:
  - next state IDLE;
  - out_valid, out_frac, out_tag, out_exact, out_err all 0;
  - the partial result is discarded;
  - in_ready is 0 during the rst cycle.

## Structure
- flog_pkg additions:
  - default constants MAN_W_LOG=16, FRAC_W_LOG=16, TAG_W_LOG=4;
  - state enum typedef (IDLE/EVAL/DONE, 2 bits).
- Sub-module log2_sq_step (combinational): in x[MAN_W-1:0]; out bit, x_next[MAN_W-1:0], is_one. It contains the multiplier, normalisation select and 1.0 compare, and is reusable for a future unrolled/pipelined version.
- Top holds the FSM, counter, and x/frac/tag/flag registers.

## Test plan
- All tests use MAN_W=16 and FRAC_W=16; 1.0 = 0x8000.
- in_man=0x8000, tag=0x3 -> out_frac=0x0000, out_exact=1, out_err=0, out_tag=0x3; out_valid 1 cycle after acceptance.
- in_man=0xC000 (1.5) -> out_frac[15:9]=1001010b, within 2 LSB of 0x95C0; out_exact=0; latency 16.
- in_man=0xB505 -> first bit 1, x becomes 0x8000, early exit -> out_frac=0x8000, out_exact=1; latency 2.
- in_man=0x4000 -> out_err=1, out_frac=0; out_valid the cycle after acceptance.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with in_valid=1 and new data -> outputs stable, in_ready=0, second input not taken.
  - On out_ready=1 -> IDLE, then the second input is accepted the next cycle.
- Reset mid-EVAL: assert rst at iteration 7 of 0xC000 -> all outputs 0 the next cycle, in_ready=1 after rst drops. A following 0x8000 yields the correct result.
